img_gather: RTL and testbench

IMG_GATHER -- requirements
Module: img_gather

---
 rtl/img_gather.sv | 211 +++++++++++++++++++++
 tb/tb_img_gather.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_gather.sv
// rtl/img_gather.sv - double-banked image gatherer: packs samples into words, replays whole images
//
// Collects a stream of NO_CH-bit samples into one of two image banks. Each
// bank holds IMG_LEN words of THROUGHPUT samples. When a bank fills, a read
// FSM streams it out as IMG_LEN consecutive valid words. The writer meanwhile
// moves on to the other bank.
//
// Optional feature: define IMG_GATHER_SOF_EN to let sof_in resynchronise the
// write pointer to sample 0 of a new image.
//
// Ports:
//   clk       clock
//   rst       synchronous, active-high reset; discards all buffered images
//   vld_in    input sample valid
//   data_in   one NO_CH-bit sample
//   sof_in    first-sample-of-image marker (used only with IMG_GATHER_SOF_EN)
//   rdy_out   sample accepted on vld_in && rdy_out
//   vld_out   output word valid
//   data_out  one output word, THROUGHPUT lanes; the earliest sample is in the highest lane
//   sync_err  one-cycle pulse when sof_in forced a resync (0 without IMG_GATHER_SOF_EN)

module img_gather #(
  parameter int NO_CH         = 2,
  parameter int LOG2_IMG_SIZE = 10,
  parameter int THROUGHPUT    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_in,
  input  logic [NO_CH-1:0] data_in,
  input  logic             sof_in,
  output logic             rdy_out,
  output logic             vld_out,
  output logic [NO_CH-1:0] data_out [THROUGHPUT-1:0],
  output logic             sync_err
);

  localparam int IMG_LEN = 1 << LOG2_IMG_SIZE;
  localparam int LANE_W  = (THROUGHPUT > 1) ? $clog2(THROUGHPUT) : 1;

  localparam logic [LANE_W-1:0]        LANE_MAX = LANE_W'(THROUGHPUT - 1);
  localparam logic [LANE_W-1:0]        LANE_ONE = LANE_W'(1);
  localparam logic [LOG2_IMG_SIZE-1:0] WORD_MAX = {LOG2_IMG_SIZE{1'b1}};
  localparam logic [LOG2_IMG_SIZE-1:0] WORD_ONE = LOG2_IMG_SIZE'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rd_state_t;

  // Two banks of IMG_LEN words; lane ordering matches data_out.
  logic [NO_CH-1:0] mem [2][IMG_LEN][THROUGHPUT-1:0];

  logic [1:0]               full;
  logic                     wr_bank;
  logic                     rd_bank;
  logic [LANE_W-1:0]        lane_cnt;
  logic [LOG2_IMG_SIZE-1:0] word_cnt;

  logic                     accept;
  logic                     resync;
  logic [LANE_W-1:0]        eff_lane;
  logic [LOG2_IMG_SIZE-1:0] eff_word;
  logic [LANE_W-1:0]        wr_lane;
  logic                     lane_wrap;
  logic                     wr_last;

  rd_state_t                state;
  rd_state_t                state_n;
  logic [LOG2_IMG_SIZE-1:0] rd_addr;
  logic [LOG2_IMG_SIZE-1:0] rd_addr_n;
  logic                     rd_en;
  logic                     rd_done;

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------

  // The writer stalls only while its target bank still holds an unread image.
  assign rdy_out = !rst && !full[wr_bank];
  assign accept  = vld_in && rdy_out;

`ifdef IMG_GATHER_SOF_EN
  // sof_in at a non-zero write position abandons the partial image. The beat
  // carrying sof_in becomes sample 0 of the same bank.
  assign resync = accept && sof_in && ((lane_cnt != '0) || (word_cnt != '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_err <= 1'b0;
    end else begin
      sync_err <= resync;
    end
  end
`else
  logic unused_sof;

  assign resync     = 1'b0;
  assign sync_err   = 1'b0;
  assign unused_sof = sof_in;
`endif

  // Effective write position of the current beat (sample 0 on resync).
  assign eff_lane  = resync ? '0 : lane_cnt;
  assign eff_word  = resync ? '0 : word_cnt;
  assign wr_lane   = LANE_MAX - eff_lane;
  assign lane_wrap = (eff_lane == LANE_MAX);
  assign wr_last   = accept && lane_wrap && (eff_word == WORD_MAX);

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_bank][eff_word][wr_lane] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt <= '0;
      word_cnt <= '0;
      wr_bank  <= 1'b0;
    end else if (accept) begin
      if (lane_wrap) begin
        lane_cnt <= '0;
        // The word counter wraps to 0 naturally after WORD_MAX.
        word_cnt <= eff_word + WORD_ONE;
        if (eff_word == WORD_MAX) begin
          wr_bank <= ~wr_bank;
        end
      end else begin
        lane_cnt <= eff_lane + LANE_ONE;
        word_cnt <= eff_word;
      end
    end
  end

  // The writer sets flags and the reader clears them. They never target the
  // same bank in one cycle. The writer only completes a bank that is not full.
  // The reader only releases a bank that is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
    end else begin
      if (rd_done) begin
        full[rd_bank] <= 1'b0;
      end
      if (wr_last) begin
        full[wr_bank] <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rd_addr <= '0;
      rd_bank <= 1'b0;
    end else begin
      state   <= state_n;
      rd_addr <= rd_addr_n;
      if (rd_done) begin
        rd_bank <= ~rd_bank;
      end
    end
  end

  // IDLE issues address 0 in the same cycle it sees a full bank. This keeps
  // the last-sample-to-first-word latency at two cycles. At the final address,
  // RUN rolls straight into the other bank if that bank is already full. This
  // avoids an output gap.
  always_comb begin
    state_n   = state;
    rd_addr_n = rd_addr;
    rd_en     = 1'b0;
    rd_done   = 1'b0;

    case (state)
      IDLE:    rd_en = full[rd_bank];
      RUN:     rd_en = 1'b1;
      default: rd_en = 1'b0;
    endcase

    if (rd_en) begin
      if (rd_addr == WORD_MAX) begin
        rd_done   = 1'b1;
        rd_addr_n = '0;
        state_n   = full[~rd_bank] ? RUN : IDLE;
      end else begin
        rd_addr_n = rd_addr + WORD_ONE;
        state_n   = RUN;
      end
    end
  end

  // One-cycle read latency; data_out holds its last word while vld_out is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_out  <= 1'b0;
      data_out <= '{default: '0};
    end else begin
      vld_out <= rd_en;
      if (rd_en) begin
        data_out <= mem[rd_bank][rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_img_gather.sv
// tb/tb_img_gather.sv - directed self-checking bench for img_gather (IMG_LEN=8, 2 samples per word)

module tb_img_gather;

  localparam int NO_CH = 2;
  localparam int LOG2  = 3;
  localparam int TP    = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             vld_in;
  logic [NO_CH-1:0] data_in;
  logic             sof_in;
  logic             rdy_out;
  logic             vld_out;
  logic [NO_CH-1:0] data_out [TP-1:0];
  logic             sync_err;

  img_gather #(
    .NO_CH         (NO_CH),
    .LOG2_IMG_SIZE (LOG2),
    .THROUGHPUT    (TP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .vld_in   (vld_in),
    .data_in  (data_in),
    .sof_in   (sof_in),
    .rdy_out  (rdy_out),
    .vld_out  (vld_out),
    .data_out (data_out),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output capture on the falling edge, away from the active edge.
  logic [3:0] out_q [$];
  int         cyc_q [$];
  int         se_cnt    = 0;
  int         se_cyc    = -1;
  int         stall_cnt = 0;

  always @(negedge clk) begin
    if (vld_out) begin
      out_q.push_back({data_out[1], data_out[0]});
      cyc_q.push_back(cyc);
    end
    if (sync_err) begin
      se_cnt <= se_cnt + 1;
      se_cyc <= cyc;
    end
    if (!rst && !rdy_out) stall_cnt <= stall_cnt + 1;
  end

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [1:0] sq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds one beat until accepted; acc returns the cycle of acceptance.
  task automatic send(input logic [1:0] d, input logic s, output int acc);
    int guard;
    guard   = 0;
    vld_in  = 1'b1;
    data_in = d;
    sof_in  = s;
    @(negedge clk);
    while (!rdy_out && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 200) begin
      n_assert++;
      n_fail++;
      $error("FAIL send_timeout observed=stalled expected=accepted");
    end
    acc = cyc;
    sq.push_back(d);
    @(posedge clk);
    #1;
    vld_in = 1'b0;
    sof_in = 1'b0;
  endtask

  // Word w of an image starting at sample base is {s[base+2w], s[base+2w+1]}.
  task automatic check_words(input string tag, input int qoff, input int base, input int n);
    for (int w = 0; w < n; w++) begin
      if (qoff + w < out_q.size())
        chk(tag, 32'(out_q[qoff + w]), 32'({sq[base + 2*w], sq[base + 2*w + 1]}));
    end
  endtask

  task automatic check_contig(input string tag, input int qoff, input int n, input int first);
    for (int j = 0; j < n; j++) begin
      if (qoff + j < cyc_q.size())
        chk(tag, 32'(cyc_q[qoff + j]), 32'(first + j));
    end
  endtask

  initial begin
    int         acc, a5, a15, a20, a31, a47, qb, sb, eb;
    logic [1:0] r;

    rst     = 1'b1;
    vld_in  = 1'b0;
    sof_in  = 1'b0;
    data_in = '0;

    // Reset state
    tick(3);
    @(negedge clk);
    chk("rst_vld_out", 32'(vld_out), 32'd0);
    chk("rst_data_lane0", 32'(data_out[0]), 32'd0);
    chk("rst_data_lane1", 32'(data_out[1]), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    chk("rst_rdy_out", 32'(rdy_out), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy_out", 32'(rdy_out), 32'd1);
    tick(1);

    // Single image of k mod 4
    sq.delete();
    qb = out_q.size();
    for (int k = 0; k < 16; k++) send(2'(k % 4), 1'b0, acc);
    a15 = acc;
    tick(14);
    chk("t1_word_count", 32'(out_q.size() - qb), 32'd8);
    check_contig("t1_contig", qb, 8, a15 + 2);
    check_words("t1_word", qb, 0, 8);
    if (out_q.size() >= qb + 8) begin
      chk("t1_word0", 32'(out_q[qb]), 32'h1);
      chk("t1_word7", 32'(out_q[qb + 7]), 32'hB);
    end
    @(negedge clk);
    chk("t1_idle_vld", 32'(vld_out), 32'd0);
    chk("t1_hold_data", 32'({data_out[1], data_out[0]}), 32'hB);
    tick(1);

    // Two images back-to-back
    sq.delete();
    qb = out_q.size();
    sb = stall_cnt;
    for (int k = 0; k < 32; k++) begin
      r = 2'($urandom_range(0, 3));
      send(r, 1'b0, acc);
      if (k == 15) a15 = acc;
    end
    a31 = acc;
    tick(14);
    chk("t2_word_count", 32'(out_q.size() - qb), 32'd16);
    check_contig("t2_img0", qb, 8, a15 + 2);
    check_contig("t2_img1", qb + 8, 8, a31 + 2);
    check_words("t2_word", qb, 0, 16);
    chk("t2_stalls", 32'(stall_cnt - sb), 32'd0);

    // Three images with vld_in held high
    sq.delete();
    qb = out_q.size();
    sb = stall_cnt;
    for (int k = 0; k < 48; k++) begin
      r = 2'($urandom_range(0, 3));
      send(r, 1'b0, acc);
      if (k == 15) a15 = acc;
      if (k == 31) a31 = acc;
    end
    a47 = acc;
    tick(14);
    chk("t3_word_count", 32'(out_q.size() - qb), 32'd24);
    check_contig("t3_img0", qb, 8, a15 + 2);
    check_contig("t3_img1", qb + 8, 8, a31 + 2);
    check_contig("t3_img2", qb + 16, 8, a47 + 2);
    check_words("t3_word", qb, 0, 24);
    chk("t3_stalls", 32'(stall_cnt - sb), 32'd0);

    // Random input gaps
    sq.delete();
    qb = out_q.size();
    for (int k = 0; k < 32; k++) begin
      if ($urandom_range(0, 1) == 1) tick(1);
      r = 2'($urandom_range(0, 3));
      send(r, 1'b0, acc);
      if (k == 15) a15 = acc;
    end
    a31 = acc;
    tick(14);
    chk("t4_word_count", 32'(out_q.size() - qb), 32'd16);
    check_contig("t4_img0", qb, 8, a15 + 2);
    check_contig("t4_img1", qb + 8, 8, a31 + 2);
    check_words("t4_word", qb, 0, 16);

    // Reset while an image is streaming out and 7 samples are buffered
    sq.delete();
    for (int k = 0; k < 23; k++) begin
      r = 2'($urandom_range(0, 3));
      send(r, 1'b0, acc);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("t5_mid_output", 32'(vld_out), 32'd1);
    chk("t5_rst_rdy", 32'(rdy_out), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_vld_after_rst", 32'(vld_out), 32'd0);
    chk("t5_rdy_after_rst", 32'(rdy_out), 32'd1);
    tick(1);
    sq.delete();
    qb = out_q.size();
    for (int k = 0; k < 16; k++) begin
      r = 2'($urandom_range(0, 3));
      send(r, 1'b0, acc);
    end
    a15 = acc;
    tick(14);
    chk("t5_word_count", 32'(out_q.size() - qb), 32'd8);
    check_contig("t5_contig", qb, 8, a15 + 2);
    check_words("t5_word", qb, 0, 8);

    // sof_in on sample 0 and on sample 5
    sq.delete();
    qb = out_q.size();
    eb = se_cnt;
    a5 = 0;
    for (int k = 0; k < 21; k++) begin
      r = 2'($urandom_range(0, 3));
      send(r, (k == 0 || k == 5), acc);
      if (k == 5) a5 = acc;
      if (k == 15) a15 = acc;
    end
    a20 = acc;
    tick(14);
    chk("t6_word_count", 32'(out_q.size() - qb), 32'd8);
`ifdef IMG_GATHER_SOF_EN
    chk("t6_sync_err_count", 32'(se_cnt - eb), 32'd1);
    chk("t6_sync_err_cycle", 32'(se_cyc), 32'(a5 + 1));
    check_contig("t6_contig", qb, 8, a20 + 2);
    check_words("t6_word", qb, 5, 8);
`else
    chk("t6_sync_err_count", 32'(se_cnt - eb), 32'd0);
    chk("t6_sync_err_level", 32'(sync_err), 32'd0);
    check_contig("t6_contig", qb, 8, a15 + 2);
    check_words("t6_word", qb, 0, 8);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
